mdu_sequencer: RTL and testbench

Multiply/divide unit sequencer for the P6 pipelined MIPS core, sitting beside the E-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from E, holds the HI/LO register pair, and models fixed multi-cycle latency by asserting `busy` for a programmed number of cycles. The hazard unit uses `busy` and `start` to stall any MD instruction in D.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_arith.sv | 50 +++++
 rtl/mdu_sequencer.sv | 89 ++++++++
 tb/tb_mdu_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the command codes, the FSM state type and a command classifier.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath fed by the sequencer's latched operands.
// Result packs {hi, lo}; wr_en drops for divide-by-zero and for non-arith ops.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        wr_en_o
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, den_s, den_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign a_sx   = {{32{a_i[31]}}, a_i};
  assign b_sx   = {{32{b_i[31]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide works on magnitudes; |0x80000000| stays 0x80000000 as an
  // unsigned value, so the 0x80000000 / -1 wrap falls out without a special case.
  assign a_neg = a_i[31];
  assign b_neg = b_i[31];
  assign a_mag = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag = b_neg ? (32'd0 - b_i) : b_i;
  assign den_s = (b_i == 32'd0) ? 32'd1 : b_mag;
  assign den_u = (b_i == 32'd0) ? 32'd1 : b_i;
  assign q_mag = a_mag / den_s;
  assign r_mag = a_mag % den_s;
  assign q_s   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a_neg ? (32'd0 - r_mag) : r_mag;
  assign q_u   = a_i / den_u;
  assign r_u   = a_i % den_u;

  always_comb begin
    result_o = 64'd0;
    wr_en_o  = 1'b0;
    case (op_i)
      OP_MULT:  begin result_o = prod_s;    wr_en_o = 1'b1; end
      OP_MULTU: begin result_o = prod_u;    wr_en_o = 1'b1; end
      OP_DIV:   begin result_o = {r_s, q_s}; wr_en_o = (b_i != 32'd0); end
      OP_DIVU:  begin result_o = {r_u, q_u}; wr_en_o = (b_i != 32'd0); end
      default:  begin result_o = 64'd0;     wr_en_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: owns HI/LO and fakes fixed mult/div latency via busy.
// Commands arriving while a mult/div is in flight are dropped.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  mdu_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q;
  logic [63:0] arith_result;
  logic        arith_wr_en;

  mdu_arith u_arith (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (arith_result),
    .wr_en_o  (arith_wr_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q    <= op;
                a_q     <= a;
                b_q     <= b;
                cnt_q   <= is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          // Last busy cycle: commit results so they appear as busy falls.
          if (cnt_q == CW'(1)) begin
            if (arith_wr_en) begin
              hi_q <= arith_result[63:32];
              lo_q <= arith_result[31:0];
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized self-checking bench for mdu_sequencer against a 64-bit arithmetic model.
// Checks busy each cycle of a command plus HI/LO before and after completion.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: returns busy length (0 = immediate or no-op) and the new HI/LO.
  function automatic int model_exec(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                                    input logic [31:0] hi_in, input logic [31:0] lo_in,
                                    output logic [31:0] hi_out, output logic [31:0] lo_out);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    hi_out = hi_in;
    lo_out = lo_in;
    sa = longint'($signed(a_v));
    sb = longint'($signed(b_v));
    ua = longint'(a_v);
    ub = longint'(b_v);
    case (op_v)
      OP_MULT: begin
        p = longint'(sa * sb);
        hi_out = p[63:32]; lo_out = p[31:0];
        return MULT_N;
      end
      OP_MULTU: begin
        p = ua * ub;
        hi_out = p[63:32]; lo_out = p[31:0];
        return MULT_N;
      end
      OP_DIV: begin
        if (b_v != 32'd0) begin
          q = sa / sb; r = sa % sb;
          lo_out = q[31:0]; hi_out = r[31:0];
        end
        return DIV_N;
      end
      OP_DIVU: begin
        if (b_v != 32'd0) begin
          p = ua / ub; lo_out = p[31:0];
          p = ua % ub; hi_out = p[31:0];
        end
        return DIV_N;
      end
      OP_MTHI: begin hi_out = a_v; return 0; end
      OP_MTLO: begin lo_out = a_v; return 0; end
      default: return 0;
    endcase
  endfunction

  // Issue one command from a negedge; optionally fire extra starts during the busy window.
  task automatic run_cmd(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v, input bit interfere);
    int n;
    logic [31:0] eh, el;
    n = model_exec(op_v, a_v, b_v, m_hi, m_lo, eh, el);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      check_val("busy_run", {63'd0, busy}, 64'd1);
      check_val("hi_hold", {32'd0, hi}, {32'd0, m_hi});
      check_val("lo_hold", {32'd0, lo}, {32'd0, m_lo});
      if (interfere && k >= 2 && k <= 4) begin
        start = 1'b1;
        op = (k % 2 == 0) ? OP_MTLO : OP_DIV;
        a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
    end
    check_val("busy_done", {63'd0, busy}, 64'd0);
    check_val("hi_res", {32'd0, hi}, {32'd0, eh});
    check_val("lo_res", {32'd0, lo}, {32'd0, el});
    $display("cmd op=%0d a=%h b=%h lat=%0d -> hi=%h lo=%h", op_v, a_v, b_v, n, hi, lo);
    m_hi = eh;
    m_lo = el;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_hi", {32'd0, hi}, 64'd0);
    check_val("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    run_cmd(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
    run_cmd(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_cmd(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_cmd(OP_DIVU,  32'd7,         32'd2, 1'b0);
    run_cmd(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_cmd(OP_DIVU,  32'h1234_5678, 32'd0, 1'b0);
    run_cmd(OP_MTHI,  32'h1234_5678, 32'd0, 1'b0);
    run_cmd(OP_MTLO,  32'h9ABC_DEF0, 32'd0, 1'b0);
    run_cmd(3'd6,     32'hDEAD_BEEF, 32'd1, 1'b0);
    run_cmd(OP_MULT,  32'h0001_0003, 32'hFFFF_0007, 1'b1);

    // Async reset mid-DIV must clear outputs at once and suppress the write.
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("arst_busy", {63'd0, busy}, 64'd0);
    check_val("arst_hi", {32'd0, hi}, 64'd0);
    check_val("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (12) begin
      @(negedge clk);
      check_val("post_rst_busy", {63'd0, busy}, 64'd0);
      check_val("post_rst_hi", {32'd0, hi}, 64'd0);
      check_val("post_rst_lo", {32'd0, lo}, 64'd0);
    end
    run_cmd(OP_MULT, 32'd6, 32'd7, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_cmd(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
